// File: rtl/mda_crtc_if.sv
// CPU I/O bus bundle for the MDA CRTC: address, write data, one-cycle
// read/write strobes, and the registered read-data return path.
interface mda_crtc_if;
    logic [15:0] iAddr;
    logic [7:0]  iData;
    logic        iIoWr;
    logic        iIoRd;
    logic [7:0]  oData;
    logic        oDataValid;

    modport master (
        output iAddr,
        output iData,
        output iIoWr,
        output iIoRd,
        input  oData,
        input  oDataValid
    );

    modport slave (
        input  iAddr,
        input  iData,
        input  iIoWr,
        input  iIoRd,
        output oData,
        output oDataValid
    );
endinterface

// File: rtl/mda_crtc.sv
// MC6845-style CRTC register file and cursor blink sequencer for the MDA
// text display. Decodes CPU I/O at 03B0h-03BFh (index, data, mode, status)
// and presents static display configuration to the scan-out path.
//
// Build option MDA_CRTC_READBACK_EN:
//   defined   - data-port reads of R0-R15 return the stored value
//   undefined - only R14/R15 read back (MC6845 behaviour), others read 0x00
module mda_crtc #(
    parameter int BLINK_DIV = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    mda_crtc_if.slave   bus,
    input  logic        iVSync,
    input  logic        iHBlank,
    output logic [13:0] oStartAddr,
    output logic [13:0] oCursorAddr,
    output logic [4:0]  oCursorStart,
    output logic [4:0]  oCursorEnd,
    output logic        oCursorOn,
    output logic        oVideoEn,
    output logic        oBlinkEn,
    output logic        oHiRes
);

    // Bit of the extended frame count that sets the mode-10b half-period;
    // mode 11b uses the next bit up (twice the period).
    localparam int BLINK_BIT = $clog2(BLINK_DIV);

    logic [4:0] index_q, index_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic [7:0] mode_q, mode_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;

    logic [1:0] vs_sync_q;
    logic [1:0] hb_sync_q;
    logic       vs_dly_q;
    logic       tick_q;

    // The 5-bit frame counter wraps 31->0; frame_ph toggles on each wrap so
    // the 2x half-period of mode 11b is still available at BLINK_DIV = 16.
    logic [4:0] frame_cnt_q, frame_cnt_d;
    logic       frame_ph_q, frame_ph_d;
    logic       cursor_on_q;

    logic       sel;
    logic [3:0] offs;
    logic       is_index, is_data, is_mode, is_status;
    logic       wr_en, rd_en;
    logic [7:0] status;
    logic [7:0] port_rd;
    logic [7:0] rd_mux;

    function automatic logic cursor_sel(input logic [1:0] cmode, input logic [5:0] cnt);
        case (cmode)
            2'b00:   return 1'b1;
            2'b01:   return 1'b0;
            2'b10:   return cnt[BLINK_BIT];
            default: return cnt[BLINK_BIT+1];
        endcase
    endfunction

    assign sel       = (bus.iAddr[15:4] == 12'h03B);
    assign offs      = bus.iAddr[3:0];
    assign is_index  = sel && !offs[3] && !offs[0];
    assign is_data   = sel && !offs[3] &&  offs[0];
    assign is_mode   = sel && (offs == 4'h8);
    assign is_status = sel && (offs == 4'hA);
    // A write wins over a simultaneous read; the read is dropped silently.
    assign wr_en     = sel && bus.iIoWr;
    assign rd_en     = sel && bus.iIoRd && !bus.iIoWr;

    assign status = {4'hF, vs_sync_q[1], 2'b00, hb_sync_q[1]};

    // Register-file write path
    always_comb begin
        index_d = index_q;
        regs_d  = regs_q;
        mode_d  = mode_q;
        if (wr_en) begin
            if (is_index) begin
                index_d = bus.iData[4:0];
            end else if (is_data && !index_q[4]) begin
                regs_d[index_q[3:0]] = bus.iData;
            end else if (is_mode) begin
                mode_d = bus.iData;
            end
        end
    end

    // Data-port read value for the current index
    always_comb begin
        port_rd = 8'h00;
`ifdef MDA_CRTC_READBACK_EN
        if (!index_q[4]) begin
            port_rd = regs_q[index_q[3:0]];
        end
`else
        if (index_q == 5'd14 || index_q == 5'd15) begin
            port_rd = regs_q[index_q[3:0]];
        end
`endif
    end

    // Read mux and registered return data; oData holds between reads
    always_comb begin
        rd_mux = 8'hFF;
        if (is_data) begin
            rd_mux = port_rd;
        end else if (is_status) begin
            rd_mux = status;
        end
        rvalid_d = rd_en;
        rdata_d  = rd_en ? rd_mux : rdata_q;
    end

    // Frame counter advances once per synchronized VSync rise
    always_comb begin
        {frame_ph_d, frame_cnt_d} = {frame_ph_q, frame_cnt_q};
        if (tick_q) begin
            {frame_ph_d, frame_cnt_d} = {frame_ph_q, frame_cnt_q} + 6'd1;
        end
    end

    // Register file, mode and read-return state
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            index_q  <= '0;
            mode_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            index_q  <= index_d;
            mode_q   <= mode_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            regs_q   <= regs_d;
        end
    end

    // Two-flop synchronizers plus VSync rising-edge detect into a frame tick
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            vs_sync_q <= '0;
            hb_sync_q <= '0;
            vs_dly_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vs_sync_q <= {vs_sync_q[0], iVSync};
            hb_sync_q <= {hb_sync_q[0], iHBlank};
            vs_dly_q  <= vs_sync_q[1];
            tick_q    <= vs_sync_q[1] && !vs_dly_q;
        end
    end

    // Blink counter and registered cursor visibility (glitch-free output,
    // computed from next-state so an R10 write shows on the following cycle)
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            frame_cnt_q <= '0;
            frame_ph_q  <= 1'b0;
            cursor_on_q <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            frame_ph_q  <= frame_ph_d;
            cursor_on_q <= cursor_sel(regs_d[10][6:5], {frame_ph_d, frame_cnt_d});
        end
    end

    assign bus.oData      = rdata_q;
    assign bus.oDataValid = rvalid_q;

    assign oStartAddr   = {regs_q[12][5:0], regs_q[13]};
    assign oCursorAddr  = {regs_q[14][5:0], regs_q[15]};
    assign oCursorStart = regs_q[10][4:0];
    assign oCursorEnd   = regs_q[11][4:0];
    assign oCursorOn    = cursor_on_q;
    assign oVideoEn     = mode_q[3];
    assign oBlinkEn     = mode_q[5];
    assign oHiRes       = mode_q[0];

    logic unused_mode_bits;
    assign unused_mode_bits = ^{mode_q[7:6], mode_q[4], mode_q[2:1]};

endmodule

// File: tb/tb_mda_crtc.sv
// Self-checking bench for mda_crtc: directed scenarios with literal
// expectations followed by randomized bus traffic, all compared every cycle
// against a register-level behavioural model of the CRTC.
module tb_mda_crtc;
    localparam int BLINK_DIV = 16;

    logic iClk = 1'b0;
    logic iRst;
    logic iVSync, iHBlank;
    logic [13:0] oStartAddr, oCursorAddr;
    logic [4:0]  oCursorStart, oCursorEnd;
    logic        oCursorOn, oVideoEn, oBlinkEn, oHiRes;

    mda_crtc_if bus();

    mda_crtc #(.BLINK_DIV(BLINK_DIV)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .bus(bus),
        .iVSync(iVSync),
        .iHBlank(iHBlank),
        .oStartAddr(oStartAddr),
        .oCursorAddr(oCursorAddr),
        .oCursorStart(oCursorStart),
        .oCursorEnd(oCursorEnd),
        .oCursorOn(oCursorOn),
        .oVideoEn(oVideoEn),
        .oBlinkEn(oBlinkEn),
        .oHiRes(oHiRes)
    );

    always #5 iClk = ~iClk;

    // Behavioural model state
    logic [7:0] m_regs [16];
    logic [4:0] m_idx;
    logic [7:0] m_mode;
    int         m_frames;
    logic       m_hb, m_vs;
    logic [7:0] m_odata;
    logic       m_valid;
    bit         chk_en = 0;
    bit         cur_chk_en = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_idx = 5'd0;
        m_mode = 8'h00;
        m_frames = 0;
        m_odata = 8'h00;
        m_valid = 1'b0;
    endtask

    // Expected read response: {valid, data}
    function automatic logic [8:0] m_read(input logic [15:0] a);
        logic [3:0] o;
        o = a[3:0];
        if (a[15:4] != 12'h03B) return 9'h000;
        if (o < 4'h8) begin
            if (o[0] == 1'b0) return {1'b1, 8'hFF};
            if (m_idx == 5'd14 || m_idx == 5'd15) return {1'b1, m_regs[m_idx[3:0]]};
`ifdef MDA_CRTC_READBACK_EN
            if (m_idx < 5'd16) return {1'b1, m_regs[m_idx[3:0]]};
`endif
            return {1'b1, 8'h00};
        end
        if (o == 4'hA) return {1'b1, 4'hF, m_vs, 2'b00, m_hb};
        return {1'b1, 8'hFF};
    endfunction

    task automatic m_write(input logic [15:0] a, input logic [7:0] d);
        logic [3:0] o;
        o = a[3:0];
        if (a[15:4] != 12'h03B) return;
        if (o < 4'h8 && o[0] == 1'b0) m_idx = d[4:0];
        else if (o < 4'h8 && m_idx < 5'd16) m_regs[m_idx[3:0]] = d;
        else if (o == 4'h8) m_mode = d;
    endtask

    function automatic logic m_cursor();
        case (m_regs[10][6:5])
            2'b00:   return 1'b1;
            2'b01:   return 1'b0;
            2'b10:   return ((m_frames / BLINK_DIV) % 2) == 1;
            default: return ((m_frames / (2 * BLINK_DIV)) % 2) == 1;
        endcase
    endfunction

    // Every-cycle comparison of all outputs against the model
    always @(negedge iClk) begin
        if (chk_en) begin
            chk("start_addr", oStartAddr, {m_regs[12][5:0], m_regs[13]});
            chk("cursor_addr", oCursorAddr, {m_regs[14][5:0], m_regs[15]});
            chk("cursor_start", oCursorStart, m_regs[10][4:0]);
            chk("cursor_end", oCursorEnd, m_regs[11][4:0]);
            chk("video_en", oVideoEn, m_mode[3]);
            chk("blink_en", oBlinkEn, m_mode[5]);
            chk("hi_res", oHiRes, m_mode[0]);
            chk("odata", bus.oData, m_odata);
            chk("odata_valid", bus.oDataValid, m_valid);
            if (cur_chk_en) chk("cursor_on", oCursorOn, m_cursor());
        end
    end

    // All tasks are entered and left at 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iClk); #1;
            m_valid = 1'b0;
        end
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic wr, input logic rd);
        logic [8:0] r;
        bus.iAddr = a;
        bus.iData = d;
        bus.iIoWr = wr;
        bus.iIoRd = rd;
        @(posedge iClk); #1;
        bus.iIoWr = 1'b0;
        bus.iIoRd = 1'b0;
        r = m_read(a);
        m_valid = 1'b0;
        if (rd && !wr && r[8]) begin
            m_valid = 1'b1;
            m_odata = r[7:0];
        end
        if (wr) m_write(a, d);
    endtask

    task automatic vsync_pulse();
        cur_chk_en = 0;
        iVSync = 1'b1;
        idle(6);
        m_frames++;
        cur_chk_en = 1;
        iVSync = 1'b0;
        idle(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int op;
        int toggles;
        logic prev_cur;
        logic [15:0] ra;
        logic [7:0]  rdat;

        iRst = 1'b1;
        iVSync = 1'b0;
        iHBlank = 1'b0;
        bus.iAddr = 16'h0000;
        bus.iData = 8'h00;
        bus.iIoWr = 1'b0;
        bus.iIoRd = 1'b0;
        model_reset();
        m_hb = 1'b0;
        m_vs = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        iRst = 1'b0;
        chk_en = 1;
        cur_chk_en = 1;

        // Reset state
        chk("rst_cursor_on", oCursorOn, 1);
        chk("rst_odata", bus.oData, 8'h00);
        chk("rst_valid", bus.oDataValid, 0);
        chk("rst_start", oStartAddr, 14'h0000);
        idle(1);

        // Cursor address write sequence and readback
        bus_cycle(16'h03B4, 8'h0E, 1, 0);
        bus_cycle(16'h03B5, 8'h12, 1, 0);
        bus_cycle(16'h03B4, 8'h0F, 1, 0);
        bus_cycle(16'h03B5, 8'h34, 1, 0);
        chk("lit_cursor_addr", oCursorAddr, 14'h1234);
        bus_cycle(16'h03B5, 8'h00, 0, 1);
        chk("lit_r15_read", bus.oData, 8'h34);
        chk("lit_r15_valid", bus.oDataValid, 1);
        idle(1);
        chk("lit_valid_pulse", bus.oDataValid, 0);
        chk("lit_odata_hold", bus.oData, 8'h34);

        // Mode register and unmapped reads
        bus_cycle(16'h03B8, 8'h29, 1, 0);
        chk("lit_hires", oHiRes, 1);
        chk("lit_video", oVideoEn, 1);
        chk("lit_blink", oBlinkEn, 1);
        bus_cycle(16'h03B8, 8'h00, 0, 1);
        chk("lit_mode_read", bus.oData, 8'hFF);
        bus_cycle(16'h03BC, 8'h00, 0, 1);
        chk("lit_unmapped_read", bus.oData, 8'hFF);
        bus_cycle(16'h03C5, 8'h00, 0, 1);
        chk("lit_offrange_valid", bus.oDataValid, 0);
        idle(1);

        // Status synchronizers
        iHBlank = 1'b1;
        idle(3);
        m_hb = 1'b1;
        bus_cycle(16'h03BA, 8'h00, 0, 1);
        chk("lit_status_hb", bus.oData, 8'hF1);
        cur_chk_en = 0;
        iVSync = 1'b1;
        idle(6);
        m_vs = 1'b1;
        m_frames++;
        cur_chk_en = 1;
        bus_cycle(16'h03BA, 8'h00, 0, 1);
        chk("lit_status_vs", bus.oData, 8'hF9);
        iVSync = 1'b0;
        idle(3);
        m_vs = 1'b0;
        iHBlank = 1'b0;
        idle(3);
        m_hb = 1'b0;

        // Cursor blink, mode 11b over 64 frames
        bus_cycle(16'h03B4, 8'h0A, 1, 0);
        bus_cycle(16'h03B5, 8'h60, 1, 0);
        toggles = 0;
        prev_cur = oCursorOn;
        for (int i = 0; i < 64; i++) begin
            vsync_pulse();
            if (oCursorOn !== prev_cur) toggles++;
            prev_cur = oCursorOn;
        end
        chk("lit_blink_toggles", toggles, 2);
        bus_cycle(16'h03B5, 8'h20, 1, 0);
        chk("lit_cursor_mode10", oCursorOn, 0);
        bus_cycle(16'h03B5, 8'h00, 1, 0);
        chk("lit_cursor_steady", oCursorOn, 1);

        // Non-readable register, dropped high-index writes
        bus_cycle(16'h03B4, 8'h02, 1, 0);
        bus_cycle(16'h03B5, 8'h55, 1, 0);
        bus_cycle(16'h03B5, 8'h00, 0, 1);
`ifdef MDA_CRTC_READBACK_EN
        chk("lit_r2_read", bus.oData, 8'h55);
`else
        chk("lit_r2_read", bus.oData, 8'h00);
`endif
        bus_cycle(16'h03B4, 8'h12, 1, 0);
        bus_cycle(16'h03B5, 8'hAB, 1, 0);
        chk("lit_hi_idx_start", oStartAddr, 14'h0000);
        chk("lit_hi_idx_cursor", oCursorAddr, 14'h1234);
        bus_cycle(16'h03B5, 8'h00, 0, 1);
        chk("lit_hi_idx_read", bus.oData, 8'h00);

        // Reset between index and data writes
        bus_cycle(16'h03B4, 8'h0C, 1, 0);
        bus_cycle(16'h03B5, 8'h3F, 1, 0);
        bus_cycle(16'h03B4, 8'h0C, 1, 0);
        iRst = 1'b1;
        model_reset();
        #1;
        chk("lit_mid_rst_start", oStartAddr, 14'h0000);
        chk("lit_mid_rst_cursor", oCursorAddr, 14'h0000);
        chk("lit_mid_rst_on", oCursorOn, 1);
        chk("lit_mid_rst_video", oVideoEn, 0);
        chk("lit_mid_rst_odata", bus.oData, 8'h00);
        idle(2);
        iRst = 1'b0;
        idle(1);
        bus_cycle(16'h03B5, 8'h3F, 1, 0);
        chk("lit_post_rst_start", oStartAddr, 14'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 11);
            rdat = 8'($urandom);
            ra = {12'h03B, 4'($urandom)};
            case (op)
                0, 1: begin
                    if ($urandom_range(0, 1) == 1) rdat = 8'($urandom_range(10, 15));
                    else rdat = 8'($urandom_range(0, 31));
                    bus_cycle(16'h03B4, rdat, 1, 0);
                end
                2, 3: bus_cycle(16'h03B5, rdat, 1, 0);
                4:    bus_cycle(ra, rdat, 1, 0);
                5, 6: bus_cycle(ra, rdat, 0, 1);
                7:    bus_cycle(16'h03B5, rdat, 0, 1);
                8:    bus_cycle(ra, rdat, 1, 1);
                9: begin
                    ra = 16'($urandom);
                    if (ra[15:4] == 12'h03B) ra[15] = 1'b1;
                    bus_cycle(ra, rdat, 1'($urandom), 1'($urandom));
                end
                10: begin
                    iHBlank = 1'($urandom);
                    idle(3);
                    m_hb = iHBlank;
                end
                default: vsync_pulse();
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mda_crtc.md
# mda_crtc

MC6845-compatible CRTC register file and control sequencer for the MDA text display. It decodes CPU I/O cycles at 03B0h–03BFh and holds the index, data, mode and status registers. It generates cursor blink timing from frame sync and presents static configuration (start address, cursor position and shape, enable bits) to the MDA scan-out datapath. It sits between the CPU I/O bus and the video path, in the CPU clock domain.

## Interface
Parameters:
- BLINK_DIV, 16 — frames per cursor blink half-period for mode 10b; mode 11b uses 2×BLINK_DIV; must be a power of two ≤ 16.

Ports:
- iClk  in  1  CPU domain clock
- iRst  in  1  asynchronous, active-high reset
- iAddr  in  16  I/O port address
- iData  in  8  write data
- iIoWr  in  1  I/O write strobe, one cycle per access
- iIoRd  in  1  I/O read strobe, one cycle per access
- oData  out  8  read data, registered
- oDataValid  out  1  one-cycle pulse, oData valid
- iVSync  in  1  raw vertical sync from the video domain (asynchronous)
- iHBlank  in  1  raw horizontal blank from the video domain (asynchronous)
- oStartAddr  out  14  display start address {R12[5:0],R13}
- oCursorAddr  out  14  cursor address {R14[5:0],R15}
- oCursorStart  out  5  cursor start scanline, R10[4:0]
- oCursorEnd  out  5  cursor end scanline, R11[4:0]
- oCursorOn  out  1  cursor currently visible (blink phase applied)
- oVideoEn  out  1  mode register bit 3
- oBlinkEn  out  1  mode register bit 5 (attribute blink instead of intensity)
- oHiRes  out  1  mode register bit 0

## Operation
- Decode: a cycle applies only when iAddr[15:4] == 0x03B; other addresses are ignored and produce no oDataValid.
- 03B0/2/4/6 (iAddr[3]=0, iAddr[0]=0): index register, 5 bits, written from iData[4:0]; reads return 0xFF.
- 03B1/3/5/7 (iAddr[3]=0, iAddr[0]=1): data port for R[index].
  - Writes to index 0–15 store 8 bits. Writes to index 16–31 are dropped.
  - Reads of R14/R15 return the stored value. Reads of R16/R17 (light pen) return 0x00. All other indices return 0x00.
- 03B8: mode register, write-only; reads return 0xFF.
- 03BA: status, read-only; returns {4'hF, sync_vs, 2'b00, sync_hb}. Writes are ignored.
- Other 03Bxh offsets: writes ignored, reads return 0xFF.
- Simultaneous iIoWr and iIoRd: the write is performed, the read is dropped, and oDataValid stays 0.
- iVSync and iHBlank each pass through a 2-flop synchronizer. A third flop on VSync detects rising edges (frame tick).
- Blink: a 5-bit frame counter increments on every frame tick and wraps 31→0. Cursor mode is R10[6:5]:
  - 00: oCursorOn = 1 (steady)
  - 01: oCursorOn = 0
  - 10: oCursorOn = counter bit log2(BLINK_DIV)
  - 11: oCursorOn = counter bit log2(BLINK_DIV)+1
- A write to R10 does not clear the frame counter.
- Reset values: index, R0–R15, mode, frame counter and synchronizers all 0. Outputs: oData=0x00, oDataValid=0, oStartAddr=0, oCursorAddr=0, oCursorStart=0, oCursorEnd=0, oCursorOn=1 (mode 00), oVideoEn=0, oBlinkEn=0, oHiRes=0.
- Reset asserted mid-access aborts the access; nothing is stored.

## Timing
- Register write: the configuration output reflects the new value on the cycle after the iIoWr edge (1-cycle latency).
- Read: oData and oDataValid are registered on the edge where iIoRd is sampled; valid for exactly one cycle. oData holds its value afterwards.
- Status bits lag the raw inputs by 2 cycles. The frame tick follows a raw VSync rise by 3 cycles; oCursorOn updates on the following cycle.
- Back-to-back index-write then data-write on consecutive cycles must work; the data write uses the new index.
- Configuration outputs change only on register writes, with no glitches. The consumer samples them in its own domain at frame boundaries.

## Configuration
- MDA_CRTC_READBACK_EN
  - Defined: data-port reads of R0–R15 return the stored 8-bit value. R16/R17 still return 0x00.
  - Undefined: only R14/R15 are readable, matching the MC6845, and the others return 0x00.

## Test plan
- Write 03B4←0x0E, 03B5←0x12, 03B4←0x0F, 03B5←0x34 → oCursorAddr = 0x1234 one cycle after the last write; reading 03B5 with index 0x0F returns 0x34 with a single oDataValid pulse.
- Write 03B8←0x29 → oHiRes=1, oVideoEn=1, oBlinkEn=1. Read 03B8 → 0xFF. Read unmapped 03B0h+0xC → 0xFF. Read 0x03C5 → no oDataValid.
- Hold iHBlank=1, iVSync=0, then read 03BA → 0xF1 (status bits lag the inputs by 2 cycles). Set iVSync=1 and read after ≥2 cycles → 0xF9.
- R10←0x60 (mode 11), apply 64 VSync pulses → oCursorOn toggles every 32 frames. R10←0x20 → oCursorOn=0 on the next cycle. R10←0x00 → 1.
- Write index 0x02 with data 0x55 and read back → 0x00 with the macro undefined, 0x55 with it defined. Write index 0x12 → no register changes.
- Assert iRst between index and data writes → all outputs return to their reset values immediately. The following data write targets R0.
